// File: rtl/mem_read_arbiter_if.sv
// Read-path bundle between the two cache refill engines, the arbiter and the
// memory read channel. The arbiter attaches through the slave modport; the
// environment (caches and memory model) attaches through the master modport.
interface mem_read_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  // I-cache side
  logic                  i_arvalid;
  logic [ADDR_WIDTH-1:0] i_araddr;
  logic [7:0]            i_arlen;
  logic                  i_arready;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  // D-cache side
  logic                  d_arvalid;
  logic [ADDR_WIDTH-1:0] d_araddr;
  logic [7:0]            d_arlen;
  logic                  d_arready;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  // Memory read channel
  logic                  m_arvalid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [3:0]            m_arid;
  logic                  m_arready;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [3:0]            m_rid;
  logic                  m_rready;

  // Sticky protocol error
  logic                  err;

  modport slave (
    input  i_arvalid, i_araddr, i_arlen,
    output i_arready, i_rvalid, i_rdata,
    input  d_arvalid, d_araddr, d_arlen,
    output d_arready, d_rvalid, d_rdata,
    output m_arvalid, m_araddr, m_arlen, m_arid,
    input  m_arready, m_rvalid, m_rdata, m_rid,
    output m_rready,
    output err
  );

  modport master (
    output i_arvalid, i_araddr, i_arlen,
    input  i_arready, i_rvalid, i_rdata,
    output d_arvalid, d_araddr, d_arlen,
    input  d_arready, d_rvalid, d_rdata,
    input  m_arvalid, m_araddr, m_arlen, m_arid,
    output m_arready, m_rvalid, m_rdata, m_rid,
    input  m_rready,
    input  err
  );

endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester read arbiter for the shared memory AXI read port.
// One refill burst is in flight at a time. The burst length is counted
// rather than taken from RLAST. Beats carrying an unexpected ID, or beats
// arriving while no burst is outstanding, are dropped and flagged.
module mem_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  ID_I       = 4'd0,
  parameter logic [3:0]  ID_D       = 4'd1,
  parameter bit          D_PRIORITY = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  mem_read_arbiter_if.slave bus
);

  localparam int unsigned LEN_WIDTH = 8;
  localparam int unsigned ID_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_t;

  state_t                state_q;
  state_t                state_d;
  req_t                  grant_q;
  req_t                  last_grant_q;
  req_t                  winner_c;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [LEN_WIDTH-1:0]  beat_cnt_q;
  logic                  err_q;

  logic [LEN_WIDTH-1:0]  eff_len_c;
  logic                  accept_c;
  logic                  addr_hs_c;
  logic                  beat_hit_c;
  logic                  final_beat_c;
  logic                  stray_c;
  logic                  fwd_i_c;
  logic                  fwd_d_c;

  // A zero length field still moves one beat.
  assign eff_len_c = (len_q == LEN_WIDTH'(0)) ? LEN_WIDTH'(1) : len_q;

  // Winner selection among the pending requests; only consumed in IDLE.
  always_comb begin
    winner_c = REQ_I;
    if (bus.i_arvalid && bus.d_arvalid) begin
      if (D_PRIORITY) begin
        winner_c = REQ_D;
      end else begin
        winner_c = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
      end
    end else if (bus.d_arvalid) begin
      winner_c = REQ_D;
    end
  end

  // Burst sequencing: next state and per-cycle event strobes.
  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    addr_hs_c    = 1'b0;
    beat_hit_c   = 1'b0;
    final_beat_c = 1'b0;
    stray_c      = 1'b0;
    case (state_q)
      IDLE: begin
        stray_c = bus.m_rvalid;
        if (bus.i_arvalid || bus.d_arvalid) begin
          accept_c = 1'b1;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        stray_c = bus.m_rvalid;
        if (bus.m_arready) begin
          addr_hs_c = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bus.m_rvalid) begin
          if (bus.m_rid == id_q) begin
            beat_hit_c = 1'b1;
            if (beat_cnt_q == (eff_len_c - LEN_WIDTH'(1))) begin
              final_beat_c = 1'b1;
              state_d      = IDLE;
            end
          end else begin
            stray_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request; it is replayed on the memory address channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      grant_q      <= REQ_I;
      last_grant_q <= REQ_I;
    end else if (accept_c) begin
      grant_q      <= winner_c;
      last_grant_q <= winner_c;
      if (winner_c == REQ_D) begin
        addr_q <= bus.d_araddr;
        len_q  <= bus.d_arlen;
        id_q   <= ID_D;
      end else begin
        addr_q <= bus.i_araddr;
        len_q  <= bus.i_arlen;
        id_q   <= ID_I;
      end
    end
  end

  // Count accepted beats of the current burst; restart at the address handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else if (addr_hs_c) begin
      beat_cnt_q <= '0;
    end else if (beat_hit_c && !final_beat_c) begin
      beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
    end else if (final_beat_c) begin
      beat_cnt_q <= eff_len_c;
    end
  end

  // Sticky error on any dropped beat; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (stray_c) begin
      err_q <= 1'b1;
    end
  end

  // Beat steering: only the granted cache sees matching beats.
  always_comb begin
    fwd_i_c = 1'b0;
    fwd_d_c = 1'b0;
    if (rst_n && beat_hit_c) begin
      fwd_i_c = (grant_q == REQ_I);
      fwd_d_c = (grant_q == REQ_D);
    end
  end

  // Requester-side outputs; reset holds them quiet.
  always_comb begin
    bus.i_arready = rst_n && accept_c && (winner_c == REQ_I);
    bus.d_arready = rst_n && accept_c && (winner_c == REQ_D);
    bus.i_rvalid  = fwd_i_c;
    bus.d_rvalid  = fwd_d_c;
    bus.i_rdata   = fwd_i_c ? bus.m_rdata : '0;
    bus.d_rdata   = fwd_d_c ? bus.m_rdata : '0;
  end

  // Memory-side outputs, driven from the captured request.
  always_comb begin
    bus.m_arvalid = rst_n && (state_q == ADDR);
    bus.m_araddr  = addr_q;
    bus.m_arlen   = len_q;
    bus.m_arid    = id_q;
    bus.m_rready  = 1'b1;
    bus.err       = err_q;
  end

endmodule
